// File: rtl/tick_scheduler_pkg.sv
// Shared encodings and widths for the tick scheduler: command modes, FSM states
// and the mode-to-state mapping used when a command takes effect.
package tick_scheduler_pkg;

  localparam int unsigned DIV_W         = 32;
  localparam int unsigned MODE_W        = 2;
  localparam int unsigned TICK_CNT_W    = 16;
  localparam int unsigned DIV_RESET_VAL = 25_000_000;

  typedef enum logic [MODE_W-1:0] {
    MODE_STOP     = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_ONESHOT  = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SHOT = 2'd2
  } state_e;

  // Reserved mode behaves as STOP.
  function automatic state_e mode_to_state(mode_e mode);
    case (mode)
      MODE_PERIODIC: return S_RUN;
      MODE_ONESHOT:  return S_SHOT;
      default:       return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// Command channel of the tick scheduler: divide ratio and mode over valid/ready.
interface tick_scheduler_if
  import tick_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
) ();

  logic [WIDTH-1:0]  cfg_div;
  logic [MODE_W-1:0] cfg_mode;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_div, output cfg_mode, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_div, input cfg_mode, input cfg_valid, output cfg_ready);

endinterface

// File: rtl/tick_scheduler_period_counter.sv
// Period counter: counts 0..div_i while enabled and flags the period-end cycle.
module tick_scheduler_period_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             at_end_o
);

  logic [WIDTH-1:0] cnt_q;

  assign at_end_o = en_i && (cnt_q == div_i);
  assign cnt_o    = cnt_q;

  always_ff @(posedge clk) begin
    if (rst || load_i) begin
      cnt_q <= '0;
    end else if (at_end_o) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Programmable clock-enable scheduler: one-cycle tick and 50% toggle at each
// period end, with ratio/mode commands applied only on period boundaries.
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH       = DIV_W,
  parameter int unsigned DEFAULT_DIV = DIV_RESET_VAL,
  parameter bit          AUTOSTART   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  tick_scheduler_if.slave       cfg,
  output logic                  tick,
  output logic                  toggle_out,
  output logic                  busy,
  output logic [TICK_CNT_W-1:0] tick_count
);

  localparam state_e RESET_STATE = AUTOSTART ? S_RUN : S_IDLE;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      div_q, div_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0]      pend_div_q, pend_div_d;
  mode_e                 pend_mode_q, pend_mode_d;
  logic                  tick_q, toggle_q, busy_q, cfg_ready_q;
  logic [TICK_CNT_W-1:0] tick_count_q;

  logic             running;
  logic             period_end;
  logic             accept;
  mode_e            cmd_mode;
  logic [WIDTH-1:0] cnt;

  assign running  = (state_q != S_IDLE);
  assign accept   = cfg.cfg_valid && cfg_ready_q;
  assign cmd_mode = mode_e'(cfg.cfg_mode);

  tick_scheduler_period_counter #(.WIDTH(WIDTH)) u_period_counter (
    .clk      (clk),
    .rst      (rst),
    .load_i   (!running),
    .en_i     (running),
    .div_i    (div_q),
    .cnt_o    (cnt),
    .at_end_o (period_end)
  );

  // Commands land at once in IDLE, at a period end, or wait in the pending slot.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    pend_valid_d = pend_valid_q;
    pend_div_d   = pend_div_q;
    pend_mode_d  = pend_mode_q;
    if (!running) begin
      if (accept && (mode_to_state(cmd_mode) != S_IDLE)) begin
        state_d = mode_to_state(cmd_mode);
        div_d   = cfg.cfg_div;
      end
    end else if (period_end) begin
      if (pend_valid_q) begin
        state_d      = mode_to_state(pend_mode_q);
        div_d        = pend_div_q;
        pend_valid_d = 1'b0;
      end else if (accept) begin
        state_d = mode_to_state(cmd_mode);
        div_d   = cfg.cfg_div;
      end else if (state_q == S_SHOT) begin
        state_d = S_IDLE;
      end
    end else if (accept) begin
      pend_valid_d = 1'b1;
      pend_div_d   = cfg.cfg_div;
      pend_mode_d  = cmd_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RESET_STATE;
      div_q        <= WIDTH'(DEFAULT_DIV);
      pend_valid_q <= 1'b0;
      pend_div_q   <= '0;
      pend_mode_q  <= MODE_STOP;
      tick_q       <= 1'b0;
      toggle_q     <= 1'b0;
      busy_q       <= AUTOSTART;
      cfg_ready_q  <= 1'b1;
      tick_count_q <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      pend_valid_q <= pend_valid_d;
      pend_div_q   <= pend_div_d;
      pend_mode_q  <= pend_mode_d;
      tick_q       <= period_end;
      busy_q       <= (state_d != S_IDLE);
      cfg_ready_q  <= !pend_valid_d;
      if (period_end) begin
        toggle_q     <= ~toggle_q;
        tick_count_q <= tick_count_q + TICK_CNT_W'(1);
      end
    end
  end

  // The running count never passes the active ratio, even across ratio changes.
  cnt_within_div: assert property (@(posedge clk) disable iff (rst) cnt <= div_q);

  assign cfg.cfg_ready = cfg_ready_q;
  assign tick          = tick_q;
  assign toggle_out    = toggle_q;
  assign busy          = busy_q;
  assign tick_count    = tick_count_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: directed scenarios plus randomized commands, every
// cycle compared against a countdown-based reference model of the scheduler.
module tb_tick_scheduler;

  localparam int unsigned DIV0  = 4;
  localparam int          LIMIT = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick, toggle_out, busy;
  logic [15:0] tick_count;

  tick_scheduler_if #(.WIDTH(32)) bus ();

  tick_scheduler #(
    .WIDTH       (32),
    .DEFAULT_DIV (DIV0),
    .AUTOSTART   (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg        (bus),
    .tick       (tick),
    .toggle_out (toggle_out),
    .busy       (busy),
    .tick_count (tick_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: time-to-next-tick countdown plus a FIFO of pending commands.
  typedef struct {
    logic [31:0] div;
    logic [1:0]  mode;
  } cmd_t;

  cmd_t        pend_q[$];
  bit          m_active, m_oneshot, m_tick, m_toggle, m_accepted;
  longint      m_ratio, m_remaining;
  int unsigned m_count;

  function automatic void model_apply(input cmd_t c);
    m_active    = (c.mode == 2'd1) || (c.mode == 2'd2);
    m_oneshot   = (c.mode == 2'd2);
    m_ratio     = longint'(c.div);
    m_remaining = m_ratio + 1;
  endfunction

  function automatic void model_edge(input logic v, input logic [31:0] d, input logic [1:0] m,
                                     input logic r);
    cmd_t c;
    c.div  = d;
    c.mode = m;
    m_accepted = 1'b0;
    if (r) begin
      pend_q.delete();
      m_active = 1'b1; m_oneshot = 1'b0; m_tick = 1'b0; m_toggle = 1'b0; m_count = 0;
      m_ratio = longint'(DIV0); m_remaining = m_ratio + 1;
      return;
    end
    m_accepted = v && (pend_q.size() == 0);
    m_tick = 1'b0;
    if (!m_active) begin
      if (m_accepted && (m == 2'd1 || m == 2'd2)) model_apply(c);
    end else begin
      m_remaining--;
      if (m_remaining == 0) begin
        m_tick   = 1'b1;
        m_toggle = !m_toggle;
        m_count  = (m_count + 1) % 65536;
        if (pend_q.size() > 0) model_apply(pend_q.pop_front());
        else if (m_accepted) model_apply(c);
        else if (m_oneshot) m_active = 1'b0;
        else m_remaining = m_ratio + 1;
      end else if (m_accepted) begin
        pend_q.push_back(c);
      end
    end
  endfunction

  task automatic step(input logic v, input logic [31:0] d, input logic [1:0] m, input logic r);
    rst           = r;
    bus.cfg_valid = v;
    bus.cfg_div   = d;
    bus.cfg_mode  = m;
    @(posedge clk);
    model_edge(v, d, m, r);
    #1;
    check("tick", 32'(tick), 32'(m_tick));
    check("toggle_out", 32'(toggle_out), 32'(m_toggle));
    check("busy", 32'(busy), 32'(m_active));
    check("tick_count", 32'(tick_count), m_count);
    check("cfg_ready", 32'(bus.cfg_ready), 32'(pend_q.size() == 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 2'd0, 1'b0);
  endtask

  // Hold a command on the bus until it is taken.
  task automatic send(input logic [31:0] d, input logic [1:0] m);
    int n   = 0;
    bit got = 1'b0;
    while (!got && n < LIMIT) begin
      step(1'b1, d, m, 1'b0);
      got = m_accepted;
      n++;
    end
    bus.cfg_valid = 1'b0;
    check("send_accepted", 32'(got), 32'd1);
  endtask

  // Advance until the model is running with the given cycles left to its period end.
  task automatic wait_remaining(input longint target);
    int n = 0;
    while ((!m_active || m_remaining != target) && n < LIMIT) begin
      step(1'b0, 32'd0, 2'd0, 1'b0);
      n++;
    end
    check("wait_in_budget", 32'(n < LIMIT), 32'd1);
  endtask

  initial begin
    logic        hv;
    logic [31:0] hd;
    logic [1:0]  hm;
    logic        r;

    rst = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = '0;
    bus.cfg_mode  = '0;

    step(1'b0, 32'd0, 2'd0, 1'b1);
    step(1'b0, 32'd0, 2'd0, 1'b1);
    idle(20);

    // Stop, then a single one-shot period of div=2.
    send(32'd0, 2'd0);
    idle(10);
    send(32'd2, 2'd2);
    idle(10);

    // Ratio change requested mid-period at cnt=1.
    send(32'd4, 2'd1);
    wait_remaining(4);
    send(32'd1, 2'd1);
    idle(14);

    // Second command held while the pending slot is full.
    send(32'd3, 2'd1);
    idle(8);
    send(32'd2, 2'd1);
    send(32'd5, 2'd1);
    idle(20);

    // Command accepted exactly on a period-end edge with div=0.
    wait_remaining(1);
    send(32'd0, 2'd1);
    idle(10);

    // Reset at cnt=2 with a STOP pending.
    send(32'd3, 2'd1);
    idle(6);
    wait_remaining(3);
    send(32'd0, 2'd0);
    step(1'b0, 32'd0, 2'd0, 1'b1);
    idle(12);

    // Randomized commands with occasional resets.
    hv = 1'b0; hd = '0; hm = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!hv && $urandom_range(0, 7) == 0) begin
        hv = 1'b1;
        hd = 32'($urandom_range(0, 6));
        hm = 2'($urandom_range(0, 3));
      end
      r = ($urandom_range(0, 299) == 0);
      step(hv, hd, hm, r);
      if (m_accepted || r) hv = 1'b0;
    end

    // tick_count wrap at div=0.
    step(1'b0, 32'd0, 2'd0, 1'b1);
    send(32'd0, 2'd1);
    idle(65545);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
Programmable clock-enable scheduler that owns the slow-rate divider used by the lab designs. It accepts divide-ratio and mode commands over a valid/ready handshake and applies them glitch-free at period boundaries. It produces a one-cycle `tick` enable and a 50%-duty `toggle_out` square wave. Downstream logic consumes `tick` as a clock enable; `toggle_out` drives a BUFG where a real clock is needed.

Parameters:
- WIDTH, 32, width of the divide ratio and period counter.
- DEFAULT_DIV, 25_000_000, divide ratio loaded at reset (period = DIV+1 cycles).
- AUTOSTART, 1, when 1 reset enters RUN with DEFAULT_DIV; when 0 reset enters IDLE.

Ports:
- clk  in  1  system clock; all logic is on the posedge.
- rst  in  1  synchronous, active-high reset.
- cfg_div  in  WIDTH  requested divide ratio N; period = N+1 clk cycles.
- cfg_mode  in  2  0 = STOP, 1 = PERIODIC, 2 = ONESHOT, 3 = reserved (treated as STOP).
- cfg_valid  in  1  command valid.
- cfg_ready  out  1  command can be accepted; a transfer occurs when cfg_valid && cfg_ready at a posedge.
- tick  out  1  registered one-cycle pulse at each period end.
- toggle_out  out  1  registered; inverts on each period end.
- busy  out  1  high in RUN or SHOT.
- tick_count  out  16  number of ticks since reset; wraps 0xFFFF->0.

Behaviour:
- Synchronous reset (rst=1 at a posedge) sets:
  - cnt=0, div_active=DEFAULT_DIV, pending empty.
  - tick=0, toggle_out=0, tick_count=0, cfg_ready=1.
  - state=RUN if AUTOSTART else IDLE.
- Reset asserted mid-period discards the active period and any pending command.
- States:
  - IDLE: counter held at 0; tick=0; toggle_out holds its value.
  - RUN: periodic operation.
  - SHOT: single period, then IDLE.
- Per-cycle operation in RUN and SHOT:
  - If cnt==div_active (period end): cnt<=0, tick<=1, toggle_out<=~toggle_out, tick_count<=tick_count+1.
  - Otherwise: cnt<=cnt+1, tick<=0.
- div_active=0 gives tick high every cycle and toggle_out at clk/2.
- Timing from an IDLE accept: with the command accepted at edge E, the first tick is visible in the cycle after edge E+N+1. Subsequent ticks occur every N+1 cycles.
- IDLE accept: the command applies at the accept edge.
  - PERIODIC -> RUN; ONESHOT -> SHOT; both load div_active=cfg_div and cnt=0.
  - STOP leaves the block in IDLE with no state change.
- RUN/SHOT accept: the command goes into a one-deep pending register and cfg_ready deasserts the next cycle.
  - At the next period end the pending command applies: div_active<=pending div, cnt<=0, state per mode (STOP -> IDLE).
  - That period-end tick is still emitted using the old ratio.
  - cfg_ready reasserts the cycle after application.
- Simultaneous accept and period end (pending empty): the command applies at that same edge, bypassing the pending register.
- SHOT with no pending command: after its single period-end tick, state returns to IDLE.
- cfg_ready is 1 whenever the pending register is empty, including in IDLE.
- busy is registered: 1 in RUN/SHOT, 0 in IDLE.

Decomposition:
- Shared include `clock_defs.vh`: mode encodings MODE_STOP/MODE_PERIODIC/MODE_ONESHOT, state encodings S_IDLE/S_RUN/S_SHOT, DEFAULT_DIV value.
- Sub-module `period_counter`:
  - Inputs: WIDTH-bit counter, load, enable, div.
  - Outputs: cnt and the `at_end` flag.
- The FSM, pending register and outputs stay in tick_scheduler.

Test Plan:
- Reset with AUTOSTART=1, DEFAULT_DIV=4 -> tick pulses every 5 cycles; toggle_out period 10 cycles; tick_count=3 after 15 cycles.
- AUTOSTART=0; in IDLE send {div=2, ONESHOT} -> exactly one tick, 3 cycles after the accept edge; busy falls the next cycle; toggle_out stays 1 thereafter.
- RUN at div=4; send {div=1, PERIODIC} at cnt=1 -> cfg_ready low until the period end; that tick still arrives on the 5-cycle grid, then ticks every 2 cycles.
- RUN at div=3; second cfg_valid held while pending is full -> not accepted until cfg_ready returns; no command lost or duplicated.
- Command accepted exactly on a period-end edge with div=0 -> tick high continuously from the next period; toggle_out at clk/2.
- rst asserted at cnt=2 with pending STOP -> all outputs return to reset values the next cycle; pending is discarded; tick_count wrap is checked separately by running 65536 ticks at div=0.
